// File: rtl/matched_filter_ctrl.sv
// Matched-filter sequencer: coefficient load, one frame streamed into the FIR, then a LENGTH-1 zero flush.
// All outputs are flops; samples reach the FIR one cycle after acceptance, and dataInReady is held only in STREAM.
module matched_filter_ctrl #(
  parameter int LENGTH       = 10000,
  parameter int DATA_WIDTH   = 16,
  parameter int FRAME_LEN    = 20000,
  parameter int LOAD_TIMEOUT = LENGTH + 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         reloadCoeff,
  input  logic                         coeffSetFlag,
  output logic                         coeffEnable,
  output logic                         firCoeffLoad,
  input  logic                         dataInValid,
  input  logic signed [DATA_WIDTH-1:0] dataInRe,
  input  logic signed [DATA_WIDTH-1:0] dataInIm,
  output logic                         dataInReady,
  output logic                         firDataValid,
  output logic signed [DATA_WIDTH-1:0] firDataRe,
  output logic signed [DATA_WIDTH-1:0] firDataIm,
  output logic                         busy,
  output logic                         frameDone,
  output logic                         errorFlag
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD_COEFF = 3'd1;
  localparam logic [2:0] STREAM     = 3'd2;
  localparam logic [2:0] FLUSH      = 3'd3;
  localparam logic [2:0] DONE       = 3'd4;
  localparam logic [2:0] ERROR      = 3'd5;

  localparam int LCW = $clog2(LOAD_TIMEOUT) + 1;
  localparam int SCW = $clog2(FRAME_LEN) + 1;
  localparam int FCW = $clog2(LENGTH) + 1;
  localparam logic [LCW-1:0] LOAD_LAST  = LCW'(LOAD_TIMEOUT - 1);
  localparam logic [SCW-1:0] SAMP_LAST  = SCW'(FRAME_LEN - 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(LENGTH - 1);

  logic [2:0]     state;
  logic           coeff_loaded;
  logic [LCW-1:0] load_cnt;
  logic [SCW-1:0] samp_cnt;
  logic [FCW-1:0] flush_cnt;

  // Outputs are assigned together with the state they belong to, so each is valid in the same cycle as that state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      coeff_loaded <= 1'b0;
      load_cnt     <= '0;
      samp_cnt     <= '0;
      flush_cnt    <= '0;
      coeffEnable  <= 1'b0;
      firCoeffLoad <= 1'b0;
      dataInReady  <= 1'b0;
      firDataValid <= 1'b0;
      firDataRe    <= '0;
      firDataIm    <= '0;
      busy         <= 1'b0;
      frameDone    <= 1'b0;
      errorFlag    <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      if (state != IDLE && abort) begin
        state        <= IDLE;
        load_cnt     <= '0;
        samp_cnt     <= '0;
        flush_cnt    <= '0;
        coeffEnable  <= 1'b0;
        firCoeffLoad <= 1'b0;
        dataInReady  <= 1'b0;
        firDataValid <= 1'b0;
        firDataRe    <= '0;
        firDataIm    <= '0;
        busy         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              busy      <= 1'b1;
              load_cnt  <= '0;
              samp_cnt  <= '0;
              flush_cnt <= '0;
              if (!coeff_loaded || reloadCoeff) begin
                state        <= LOAD_COEFF;
                coeff_loaded <= 1'b0;
                coeffEnable  <= 1'b1;
                firCoeffLoad <= 1'b1;
              end else begin
                state       <= STREAM;
                dataInReady <= 1'b1;
              end
            end
          end
          LOAD_COEFF: begin
            if (coeffSetFlag) begin
              state        <= STREAM;
              coeff_loaded <= 1'b1;
              coeffEnable  <= 1'b0;
              firCoeffLoad <= 1'b0;
              dataInReady  <= 1'b1;
              load_cnt     <= '0;
            end else if (load_cnt == LOAD_LAST) begin
              state        <= ERROR;
              coeffEnable  <= 1'b0;
              firCoeffLoad <= 1'b0;
              errorFlag    <= 1'b1;
              load_cnt     <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
          STREAM: begin
            if (dataInValid && dataInReady) begin
              firDataValid <= 1'b1;
              firDataRe    <= dataInRe;
              firDataIm    <= dataInIm;
              if (samp_cnt == SAMP_LAST) begin
                samp_cnt    <= '0;
                dataInReady <= 1'b0;
                // A single-tap filter has no delay line to flush.
                if (LENGTH > 1) begin
                  state <= FLUSH;
                end else begin
                  state     <= DONE;
                  frameDone <= 1'b1;
                end
              end else begin
                samp_cnt <= samp_cnt + 1'b1;
              end
            end else begin
              firDataValid <= 1'b0;
            end
          end
          FLUSH: begin
            if (flush_cnt == FLUSH_LAST) begin
              state        <= DONE;
              firDataValid <= 1'b0;
              frameDone    <= 1'b1;
              flush_cnt    <= '0;
            end else begin
              firDataValid <= 1'b1;
              firDataRe    <= '0;
              firDataIm    <= '0;
              flush_cnt    <= flush_cnt + 1'b1;
            end
          end
          DONE: begin
            state        <= IDLE;
            busy         <= 1'b0;
            firDataValid <= 1'b0;
          end
          ERROR: begin
            errorFlag <= 1'b1;
          end
          default: begin
            state        <= IDLE;
            load_cnt     <= '0;
            samp_cnt     <= '0;
            flush_cnt    <= '0;
            coeffEnable  <= 1'b0;
            firCoeffLoad <= 1'b0;
            dataInReady  <= 1'b0;
            firDataValid <= 1'b0;
            firDataRe    <= '0;
            firDataIm    <= '0;
            busy         <= 1'b0;
            errorFlag    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matched_filter_ctrl.sv
// Bench for matched_filter_ctrl: timeline-based reference model checked every cycle, plus directed literal checks.
module tb_matched_filter_ctrl;
  localparam int LENGTH       = 8;
  localparam int DW           = 16;
  localparam int FRAME_LEN    = 16;
  localparam int LOAD_TIMEOUT = 16;

  logic clock = 1'b0, reset = 1'b1;
  logic start = 1'b0, abort = 1'b0, reloadCoeff = 1'b0, coeffSetFlag = 1'b0, dataInValid = 1'b0;
  logic signed [DW-1:0] dataInRe = '0, dataInIm = '0;
  logic coeffEnable, firCoeffLoad, dataInReady, firDataValid, busy, frameDone, errorFlag;
  logic signed [DW-1:0] firDataRe, firDataIm;

  int errors = 0, checks = 0;

  matched_filter_ctrl #(.LENGTH(LENGTH), .DATA_WIDTH(DW), .FRAME_LEN(FRAME_LEN),
                        .LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .reloadCoeff(reloadCoeff),
    .coeffSetFlag(coeffSetFlag), .coeffEnable(coeffEnable), .firCoeffLoad(firCoeffLoad),
    .dataInValid(dataInValid), .dataInRe(dataInRe), .dataInIm(dataInIm), .dataInReady(dataInReady),
    .firDataValid(firDataValid), .firDataRe(firDataRe), .firDataIm(firDataIm), .busy(busy),
    .frameDone(frameDone), .errorFlag(errorFlag));

  always #5 clock = ~clock;

  // Reference model: phases plus absolute cycle arithmetic from the frame timeline.
  localparam int P_IDLE = 0, P_LOAD = 1, P_STREAM = 2, P_TAIL = 3, P_ERR = 4;
  int cyc = 0, phase = P_IDLE, load_entry = 0, acc = 0, last_acc = 0;
  bit m_loaded = 1'b0, m_err = 1'b0;
  logic e_cen = 1'b0, e_rdy = 1'b0, e_fv = 1'b0, e_busy = 1'b0, e_fd = 1'b0;
  logic [DW-1:0] e_re = '0, e_im = '0;

  // Bench-side observation and stub state.
  int n_acc = 0, cen_cyc = 0, fd_cnt = 0, st_cnt = 0, vcount = 0, rdy1 = 0;
  bit stub_ok = 1'b1;
  logic [DW-1:0] fir_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    phase = P_IDLE; acc = 0; m_loaded = 1'b0; m_err = 1'b0;
    e_cen = 1'b0; e_rdy = 1'b0; e_fv = 1'b0; e_busy = 1'b0; e_fd = 1'b0; e_re = '0; e_im = '0;
  endtask

  // Expected outputs for the cycle following the coming clock edge, from the inputs now applied.
  task automatic model_step();
    int d;
    cyc++;
    e_fd = 1'b0;
    if (phase != P_IDLE && abort) begin
      phase = P_IDLE; e_cen = 1'b0; e_rdy = 1'b0; e_fv = 1'b0; e_re = '0; e_im = '0; e_busy = 1'b0;
    end else begin
      case (phase)
        P_IDLE: if (start) begin
          e_busy = 1'b1;
          if (!m_loaded || reloadCoeff) begin
            phase = P_LOAD; load_entry = cyc; m_loaded = 1'b0; e_cen = 1'b1;
          end else begin
            phase = P_STREAM; acc = 0; e_rdy = 1'b1;
          end
        end
        P_LOAD: if (coeffSetFlag) begin
          phase = P_STREAM; acc = 0; m_loaded = 1'b1; e_cen = 1'b0; e_rdy = 1'b1;
        end else if (cyc - load_entry == LOAD_TIMEOUT) begin
          phase = P_ERR; e_cen = 1'b0; m_err = 1'b1;
        end
        P_STREAM: if (dataInValid) begin
          e_fv = 1'b1; e_re = dataInRe; e_im = dataInIm; acc++;
          if (acc == FRAME_LEN) begin
            phase = P_TAIL; last_acc = cyc - 1; e_rdy = 1'b0;
          end
        end else begin
          e_fv = 1'b0;
        end
        P_TAIL: begin
          d = cyc - last_acc;
          if (d <= LENGTH) begin
            e_fv = 1'b1; e_re = '0; e_im = '0;
          end else if (d == LENGTH + 1) begin
            e_fv = 1'b0; e_fd = 1'b1;
          end else begin
            e_busy = 1'b0; phase = P_IDLE;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: advance the model, compare everything, record observations, then run the coefficient stub.
  task automatic tick();
    bit fire;
    fire = dataInValid && dataInReady;
    model_step();
    @(posedge clock);
    #1;
    if (fire) n_acc++;
    check($sformatf("cycle%0d", cyc),
          64'({coeffEnable, firCoeffLoad, dataInReady, firDataValid, busy, frameDone, errorFlag, firDataRe, firDataIm}),
          64'({e_cen, e_cen, e_rdy, e_fv, e_busy, e_fd, m_err, e_re, e_im}));
    if (coeffEnable) cen_cyc++;
    if (frameDone) fd_cnt++;
    if (firDataValid) fir_q.push_back(firDataRe);
    if (!coeffEnable) begin
      st_cnt = 0; coeffSetFlag = 1'b0;
    end else begin
      coeffSetFlag = stub_ok && (st_cnt == 8); st_cnt++;
    end
  endtask

  task automatic clear_stats();
    n_acc = 0; cen_cyc = 0; fd_cnt = 0; vcount = 0; fir_q.delete();
  endtask

  // mode 0: always valid, data 1..N; mode 1: valid pattern 1,0,0,1; mode 2: random valid and data.
  task automatic run_frame(input bit reload, input int mode, input int abort_at);
    bit done, aborted;
    done = 1'b0; aborted = 1'b0;
    clear_stats();
    start = 1'b1; reloadCoeff = reload;
    tick();
    start = 1'b0; reloadCoeff = 1'b0;
    rdy1 = int'(dataInReady);
    for (int c = 0; c < 300 && !done; c++) begin
      if (mode == 0) dataInValid = 1'b1;
      else if (mode == 1) dataInValid = dataInReady && ((vcount % 4 == 0) || (vcount % 4 == 3));
      else dataInValid = 1'($urandom_range(0, 1));
      if (dataInReady) vcount++;
      if (mode < 2) begin
        dataInRe = DW'(n_acc + 1); dataInIm = ~dataInRe;
      end else begin
        dataInRe = DW'($urandom); dataInIm = DW'($urandom);
      end
      tick();
      if (abort_at > 0 && n_acc == abort_at) begin
        dataInValid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0; aborted = 1'b1;
        break;
      end
      if (fd_cnt > 0 && !busy) done = 1'b1;
    end
    dataInValid = 1'b0;
    if (!done && !aborted) check("frame_budget", 64'(0), 64'(1));
  endtask

  task automatic check_seq(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < fir_q.size(); i++) begin
      logic [DW-1:0] want;
      want = (i < FRAME_LEN) ? DW'(i + 1) : '0;
      if (fir_q[i] !== want) bad++;
    end
    check({name, "_count"}, 64'(fir_q.size()), 64'(FRAME_LEN + LENGTH - 1));
    check({name, "_values"}, 64'(bad), 64'(0));
  endtask

  initial begin
    int k;
    #1 reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 64'({coeffEnable, firCoeffLoad, dataInReady, firDataValid, busy, frameDone, errorFlag, firDataRe, firDataIm}), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    tick();

    // First frame: full coefficient load, then samples 1..16 and seven flush zeros.
    run_frame(1'b0, 0, 0);
    check("f1_cen_cycles", 64'(cen_cyc), 64'(9));
    check_seq("f1_fir");
    check("f1_frame_done", 64'(fd_cnt), 64'(1));
    check("f1_busy_end", 64'(busy), 64'(0));
    tick();

    // Coefficients kept: no load, ready one cycle after start; gapped valid pattern.
    run_frame(1'b0, 1, 0);
    check("f2_cen_cycles", 64'(cen_cyc), 64'(0));
    check("f2_rdy_after_start", 64'(rdy1), 64'(1));
    check_seq("f2_fir");
    check("f2_frame_done", 64'(fd_cnt), 64'(1));

    // Forced reload.
    run_frame(1'b1, 0, 0);
    check("f3_cen_cycles", 64'(cen_cyc), 64'(9));
    check_seq("f3_fir");

    // Abort after the fifth sample, then restart without reload.
    run_frame(1'b0, 0, 5);
    check("abort_state", 64'({busy, firDataValid, dataInReady}), 64'(0));
    check("abort_samples", 64'(fir_q.size()), 64'(5));
    tick();
    run_frame(1'b0, 0, 0);
    check("post_abort_cen", 64'(cen_cyc), 64'(0));
    check("post_abort_rdy", 64'(rdy1), 64'(1));
    check_seq("post_abort_fir");

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      bit rl;
      rl = 1'($urandom_range(0, 1));
      run_frame(rl, 2, 0);
      check($sformatf("rand%0d_cen", f), 64'(cen_cyc), rl ? 64'(9) : 64'(0));
      check($sformatf("rand%0d_strobes", f), 64'(fir_q.size()), 64'(FRAME_LEN + LENGTH - 1));
      check($sformatf("rand%0d_done", f), 64'(fd_cnt), 64'(1));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Load timeout into ERROR; start ignored there; abort leaves errorFlag set.
    stub_ok = 1'b0;
    start = 1'b1; reloadCoeff = 1'b1;
    tick();
    start = 1'b0; reloadCoeff = 1'b0;
    check("timeout_entry", 64'(coeffEnable), 64'(1));
    k = 0;
    while (!errorFlag && k < 40) begin
      tick(); k++;
    end
    check("timeout_cycles", 64'(k), 64'(16));
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    check("error_hold", 64'({busy, errorFlag, dataInReady, coeffEnable}), 64'(4'b1100));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("error_abort", 64'({busy, errorFlag}), 64'(2'b01));
    stub_ok = 1'b1;
    tick();
    run_frame(1'b0, 0, 0);
    check("post_error_cen", 64'(cen_cyc), 64'(9));
    check_seq("post_error_fir");

    // Asynchronous reset in the middle of the flush.
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (n_acc < FRAME_LEN && k < 100) begin
      dataInValid = 1'b1; dataInRe = DW'(n_acc + 1); dataInIm = ~dataInRe;
      tick(); k++;
    end
    dataInValid = 1'b0;
    repeat (3) tick();
    check("flush_active", 64'({firDataValid, firDataRe, busy}), 64'({1'b1, 16'h0, 1'b1}));
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_reset", 64'({coeffEnable, firCoeffLoad, dataInReady, firDataValid, busy, frameDone, errorFlag, firDataRe, firDataIm}), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    tick();
    run_frame(1'b0, 0, 0);
    check("post_reset_cen", 64'(cen_cyc), 64'(9));
    check_seq("post_reset_fir");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
